// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit combinational full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one operand bit per clock, LSB first, through one fa_cell.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, serial shift and result collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

  // Status decoded directly from the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic fa_a = 1'b0;
  logic fa_b = 1'b0;
  logic fa_ci = 1'b0;
  logic fa_s;
  logic fa_co;

  int total = 0;
  int bad   = 0;

  logic [W:0] sb_q[$];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  fa_cell u_fa_chk (
    .a  (fa_a),
    .b  (fa_b),
    .ci (fa_ci),
    .s  (fa_s),
    .co (fa_co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one cycle at a negedge and record the expected result.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    sb_q.push_back({1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done; ncyc counts negedges since start was driven (first = 1).
  task automatic wait_done(input string tag, input int first, output int ncyc, output int nbusy);
    ncyc  = first;
    nbusy = first;
    while (!done && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (busy) nbusy++;
    end
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic score(input string tag);
    logic [W:0] e;
    chk({tag, "_sbq"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_sum"},  {24'd0, sum}, {24'd0, e[W-1:0]});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e[W]});
    end
  endtask

  initial begin
    int n;
    int nb;
    int dones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // fa_cell truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v = 3'(i);
      fa_a = v[2];
      fa_b = v[1];
      fa_ci = v[0];
      e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #1;
      chk($sformatf("fa_%0d", i), {30'd0, fa_co, fa_s}, {30'd0, e});
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outs", {22'd0, busy, done, cout, sum}, 32'd0);
    rst = 1'b0;

    // 3C + 5A.
    launch(8'h3C, 8'h5A, 1'b0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("op1", 1, n, nb);
    chk("op1_latency", n, W + 1);
    chk("op1_busy_cycles", nb, W + 1);
    chk("op1_busy_at_done", {31'd0, busy}, 32'd1);
    score("op1");
    @(negedge clk);
    chk("op1_done_pulse", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("op1_hold", {23'd0, cout, sum}, {23'd0, 9'h096});

    // FF + 01: carry ripples through every step.
    launch(8'hFF, 8'h01, 1'b0);
    wait_done("op2", 1, n, nb);
    score("op2");

    // FF + FF + 1, then 0 + 0 started in the cycle right after done.
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done("op3", 1, n, nb);
    score("op3");
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    a = '0; b = '0; cin = 1'b0; start = 1'b1;
    sb_q.push_back(9'h000);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_done("op4", 1, n, nb);
    chk("op4_latency", n, W + 1);
    score("op4");

    // Start held high, operands changed mid-SHIFT.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    sb_q.push_back(9'h030);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55;
    wait_done("op5", 3, n, nb);
    chk("op5_latency", n, W + 1);
    score("op5");
    @(negedge clk);
    chk("op5_not_requeued", {30'd0, busy, done}, 32'd0);
    sb_q.push_back(9'h0FF);
    @(negedge clk);
    start = 1'b0;
    chk("op6_accepted_idle", {31'd0, busy}, 32'd1);
    wait_done("op6", 1, n, nb);
    score("op6");

    // Asynchronous reset mid-SHIFT discards the operation.
    launch(8'h77, 8'h66, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {22'd0, busy, done, cout, sum}, 32'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (14) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("no_done_after_rst", dones, 0);
    launch(8'h01, 8'h01, 1'b0);
    wait_done("op7", 1, n, nb);
    score("op7");

    // A few random operands.
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      launch(ra, rb, 1'($urandom_range(0, 1)));
      wait_done($sformatf("rnd%0d", k), 1, n, nb);
      chk($sformatf("rnd%0d_latency", k), n, W + 1);
      score($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle adder: adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first, through a single full-adder cell.
- Carry is held in a flip-flop between cycles; sum bits shift into a result register.
- Sits directly upstream of the one-bit full-adder cell: it sequences operand bits and the stored carry into the cell, then collects S and Cout.
- Start/busy/done handshake to the surrounding controller.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 2 or more.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  initial carry; captured on the accepted start edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; sum and cout are valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  final carry-out; held with sum.

Behaviour:
- Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, operand shift regs=0.
- An operation in progress when reset asserts is discarded. No done pulse is produced for it.
- States: IDLE, SHIFT, DONE. Registered encoding from the shared package.
- IDLE, start=1 at edge E0:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0.
  - state -> SHIFT.
  - sum/cout keep their previous values until overwritten.
- IDLE, start=0: stay in IDLE; all registers hold.
- SHIFT, each edge:
  - full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - sum <= {S, sum[WIDTH-1:1]} (shift right, new bit enters at the MSB).
  - carry <= Cout.
  - a_sh and b_sh shift right by one.
  - cnt <= cnt+1.
- SHIFT, edge where cnt == WIDTH-1 (the WIDTH-th bit): after the shift, cout <= Cout and state -> DONE.
- Counter width is clog2(WIDTH+1). There is no wrap in normal operation.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - next edge -> IDLE unconditionally.
- start in SHIFT or DONE is ignored. No queueing, no effect on the result.
- Latency:
  - start accepted at E0; shifts on edges E1..EWIDTH.
  - done is high in the cycle after edge EWIDTH, i.e. WIDTH+1 cycles after start is sampled.
  - Throughput is one operation per WIDTH+2 cycles. A start in the cycle after done (IDLE) is accepted.
- Intermediate sum values during SHIFT are partial and not valid. Consumers sample sum/cout only on done, or any time afterwards while IDLE.
- Arithmetic: {cout,sum} = a + b + cin exactly, i.e. WIDTH+1 bits, unsigned.
- Outputs are all registered. There is no combinational path from start to busy or done.

Decomposition:
- Shared package holds:
  - state type/encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - default WIDTH constant (8).
- One natural sub-module, fa_cell: purely combinational one-bit full adder.
  - Inputs: a, b, ci. Outputs: s, co.
  - s = a^b^ci.
  - co = (a&b)|(a&ci)|(b&ci), i.e. majority.
  - Instantiated once inside bit_serial_adder.

Test Plan:
- WIDTH=8; a=8'h3C, b=8'h5A, cin=0, start pulsed 1 cycle -> busy high 9 cycles; done pulses exactly 9 cycles after the start edge; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Carry ripples through all 8 serial steps.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=0, b=0, cin=0 started in the cycle right after done -> accepted; sum=8'h00, cout=0 after a further 9 cycles.
- During op a=8'h10, b=8'h20, hold start=1 throughout and change a/b mid-SHIFT to 8'hAA/8'h55 -> result is still sum=8'h30, cout=0. Only one done pulse occurs. The new start is accepted only once back in IDLE.
- Assert rst asynchronously at cycle 4 of SHIFT (between clock edges) -> busy, done, sum, cout all 0 immediately. No done pulse after release. A fresh start 8'h01+8'h01 gives sum=8'h02.
- Exhaustive fa_cell check, 8 input combinations -> s/co match the truth table, e.g. (1,1,0) -> s=0, co=1; (1,0,1) -> s=0, co=1.
